// File: rtl/fsm4.sv
// Serial "110" sequence detector (Moore). Emits a one-cycle registered pulse on z
// for every detected "110" (overlaps allowed) and keeps a modulo-16 detection count.
module fsm4 (
    input  logic       clk,
    input  logic       reset,
    input  logic       in,
    output logic       z,
    output logic [3:0] count
);

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic        z_r;
    logic [3:0]  count_r;
    logic        detect_s;

    // Next-state logic and detection strobe for the S2 -> S3 transition.
    always_comb begin
        next_state_s = S0;
        detect_s     = 1'b0;
        case (state_r)
            S0: begin
                if (in) begin
                    next_state_s = S1;
                end else begin
                    next_state_s = S0;
                end
            end
            S1: begin
                if (in) begin
                    next_state_s = S2;
                end else begin
                    next_state_s = S0;
                end
            end
            S2: begin
                // A longer run of ones keeps the "11" prefix alive.
                if (in) begin
                    next_state_s = S2;
                end else begin
                    next_state_s = S3;
                    detect_s     = 1'b1;
                end
            end
            S3: begin
                if (in) begin
                    next_state_s = S1;
                end else begin
                    next_state_s = S0;
                end
            end
            default: begin
                next_state_s = S0;
                detect_s     = 1'b0;
            end
        endcase
    end

    // State register; reset overrides every transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S0;
        end else begin
            state_r <= next_state_s;
        end
    end

    // z is loaded with the decode of the state being entered, so it equals (state_r == S3).
    always_ff @(posedge clk) begin
        if (reset) begin
            z_r <= 1'b0;
        end else begin
            z_r <= (next_state_s == S3);
        end
    end

    // Detection counter, wraps naturally from 15 to 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= 4'd0;
        end else if (detect_s) begin
            count_r <= count_r + 4'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign z     = z_r;
    assign count = count_r;

endmodule

// File: tb/tb_fsm4.sv
// Scoreboard bench for fsm4: a reference built on a 3-bit history of sampled bits
// predicts z/count per edge; predictions are queued at drive time and popped after the edge.
module tb_fsm4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in = 1'b0;
    logic       z;
    logic [3:0] count;

    logic [2:0] hist_m = 3'b000;
    logic [3:0] cnt_m = 4'd0;
    logic [4:0] sb_q[$];
    int         n_checks = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    fsm4 dut (
        .clk   (clk),
        .reset (reset),
        .in    (in),
        .z     (z),
        .count (count)
    );

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one bit (optionally with reset), predict, clock, then compare.
    task automatic step(input logic rst_b, input logic in_b, input string tag);
        logic [4:0] exp_v;
        logic       hit;
        reset = rst_b;
        in    = in_b;
        if (rst_b) begin
            hist_m = 3'b000;
            cnt_m  = 4'd0;
            hit    = 1'b0;
        end else begin
            hist_m = {hist_m[1:0], in_b};
            hit    = (hist_m == 3'b110);
            if (hit) cnt_m = cnt_m + 4'd1;
        end
        sb_q.push_back({hit, cnt_m});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_eq({tag, "_sb_underflow"}, 8'd0, 8'd1);
        end else begin
            exp_v = sb_q.pop_front();
            check_eq({tag, "_z"}, {7'd0, z}, {7'd0, exp_v[4]});
            check_eq({tag, "_count"}, {4'd0, count}, {4'd0, exp_v[3:0]});
        end
    endtask

    task automatic drive_bits(input logic [15:0] bits, input int n, input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b0, bits[i], tag);
        end
    endtask

    initial begin
        @(negedge clk);
        // Reset with in low, then with in toggling.
        step(1'b1, 1'b0, "rst");
        for (int i = 0; i < 4; i++) step(1'b1, i[0], "rst_toggle");

        // Basic detect, then step into S1 and complete a second 110.
        drive_bits(16'b110, 3, "basic");
        drive_bits(16'b110, 3, "repeat");
        if (count !== 4'd2) check_eq("count_after_repeat", {4'd0, count}, 8'd2);

        // Non-match from S0.
        step(1'b0, 1'b0, "to_s0");
        drive_bits(16'b1010, 4, "nonmatch");

        // Long run of ones.
        drive_bits(16'b11110, 5, "longrun");

        // Sixteen detections wrap the counter back to its start value.
        for (int k = 0; k < 16; k++) drive_bits(16'b110, 3, "wrap");
        check_eq("wrap_total", {4'd0, count}, {4'd0, cnt_m});

        // Reset on the edge that would complete a detection from S2.
        drive_bits(16'b11, 2, "pre_rst");
        step(1'b1, 1'b0, "rst_mid");
        check_eq("rst_mid_count", {4'd0, count}, 8'd0);

        // Reset during a z pulse.
        drive_bits(16'b110, 3, "pulse");
        step(1'b1, 1'b1, "rst_pulse");

        // Random traffic with occasional resets.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), "rand");
        end

        check_eq("sb_empty", 8'(sb_q.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
